// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch sequencer: widths, FSM state
// encoding and the prefetch FIFO entry layout.
package fetch_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned INST_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: power-of-two depth, registered head, synchronous
// push/pop/flush. A push while full is legal only with a same-cycle pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = fetch_entry_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     din,
    input  logic pop,
    input  logic flush,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    T                mem_q [DEPTH];
    logic [PW-1:0]   wr_q;
    logic [PW-1:0]   rd_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            do_push;
    logic            do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_q];

    // Occupancy update from the qualified push/pop pair
    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage, pointers and occupancy; flush only rewinds the bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din;
                wr_q        <= wr_q + PW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, drives the instruction memory
// address, queues fetched words in a prefetch FIFO and hands them to
// decode over valid/ready. Redirects flush the queue and reload the PC.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [1:0]        state
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              push, pop, flush;
    logic              fifo_full, fifo_empty;
    fetch_entry_t      wdata, head;

    // Push/pop/flush control, next PC and next FSM state.
    // Redirect overrides everything: no push, no pop, state untouched.
    always_comb begin
        flush   = redirect_valid;
        pop     = !fifo_empty && inst_ready && !redirect_valid;
        push    = (state_q == RUN) && !halt && !redirect_valid && (!fifo_full || pop);
        wdata   = fetch_entry_t'{pc: pc_q, inst: imem_data};
        pc_d    = pc_q;
        state_d = state_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~ADDR_W'(3);
        end else begin
            if (push) begin
                pc_d = pc_q + ADDR_W'(4);
            end
            case (state_q)
                IDLE:    if (start && !halt) state_d = RUN;
                RUN:     if (halt)           state_d = HALT;
                HALT:    if (start && !halt) state_d = RUN;
                default:                     state_d = IDLE;
            endcase
        end
    end

    // PC and FSM registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            state_q <= IDLE;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (wdata),
        .pop   (pop),
        .flush (flush),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign imem_addr  = pc_q;
    assign inst_valid = !fifo_empty;
    assign inst_data  = head.inst;
    assign inst_pc    = head.pc;
    assign state      = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed vector tables, hand-written corner
// sequences and a randomized run, all checked against a queue-based model.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        start, halt, redirect_valid, inst_ready;
    logic [7:0]  redirect_pc;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [7:0]  inst_pc;
    logic [1:0]  state;

    logic [31:0] imem [64];
    assign imem_data = imem[imem_addr[7:2]];

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .state          (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // Reference model: a queue of fetched (pc, word) pairs, a PC and a state
    logic [7:0]  m_pc;
    int          m_st;   // 0 idle, 1 run, 2 halt
    logic [7:0]  q_pc [$];
    logic [31:0] q_in [$];

    typedef struct {
        logic        start;
        logic        ready;
        logic        exp_valid;
        logic [7:0]  exp_pc;
        logic [31:0] exp_data;
        logic [7:0]  exp_addr;
        logic [1:0]  exp_state;
    } vec_t;

    vec_t vec_a [4];
    vec_t vec_b [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_pc.delete();
        q_in.delete();
        m_pc = 8'h00;
        m_st = 0;
    endtask

    task automatic model_step();
        bit popped, pushed;
        int occ;
        if (redirect_valid) begin
            q_pc.delete();
            q_in.delete();
            m_pc = redirect_pc & 8'hFC;
        end else begin
            popped = (q_pc.size() > 0) && inst_ready;
            occ    = q_pc.size() - (popped ? 1 : 0);
            pushed = (m_st == 1) && !halt && (occ < DEPTH);
            if (popped) begin
                void'(q_pc.pop_front());
                void'(q_in.pop_front());
            end
            if (pushed) begin
                q_pc.push_back(m_pc);
                q_in.push_back(imem[m_pc / 4]);
                m_pc = m_pc + 8'd4;
            end
            if (m_st == 0 && start && !halt)      m_st = 1;
            else if (m_st == 1 && halt)           m_st = 2;
            else if (m_st == 2 && start && !halt) m_st = 1;
        end
    endtask

    task automatic check_model();
        chk("model.valid", {31'd0, inst_valid}, {31'd0, q_pc.size() > 0});
        if (q_pc.size() > 0) begin
            chk("model.pc",   {24'd0, inst_pc}, {24'd0, q_pc[0]});
            chk("model.data", inst_data, q_in[0]);
        end
        chk("model.addr",  {24'd0, imem_addr}, {24'd0, m_pc});
        chk("model.state", {30'd0, state}, m_st);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        start = 0; halt = 0; redirect_valid = 0; redirect_pc = 8'h00; inst_ready = 0;
    endtask

    // Asynchronous reset assertion away from any clock edge
    task automatic reset_assert();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        chk("rst.valid", {31'd0, inst_valid}, 32'd0);
        chk("rst.state", {30'd0, state}, 32'd0);
        chk("rst.addr",  {24'd0, imem_addr}, 32'h00);
        chk("rst.data",  inst_data, 32'd0);
        chk("rst.pc",    {24'd0, inst_pc}, 32'd0);
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string tag, input vec_t v [], input int n);
        for (int i = 0; i < n; i++) begin
            start      = v[i].start;
            inst_ready = v[i].ready;
            tick();
            chk($sformatf("%s[%0d].valid", tag, i), {31'd0, inst_valid}, {31'd0, v[i].exp_valid});
            if (v[i].exp_valid) begin
                chk($sformatf("%s[%0d].pc", tag, i), {24'd0, inst_pc}, {24'd0, v[i].exp_pc});
                chk($sformatf("%s[%0d].data", tag, i), inst_data, v[i].exp_data);
            end
            chk($sformatf("%s[%0d].addr", tag, i), {24'd0, imem_addr}, {24'd0, v[i].exp_addr});
            chk($sformatf("%s[%0d].state", tag, i), {30'd0, state}, {30'd0, v[i].exp_state});
        end
        start = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        for (int i = 0; i < 64; i++) imem[i] = $urandom;
        imem[0]  = 32'he3a01a02;
        imem[1]  = 32'he3a02002;
        imem[2]  = 32'he5812000;
        imem[22] = 32'he5912000;
        imem[23] = 32'he1e05002;
        imem[63] = 32'h00000000;

        // start, ready=1: one instruction per cycle from N+2
        vec_a[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 32'h0,         8'h00, 2'd1};
        vec_a[1] = '{1'b0, 1'b1, 1'b1, 8'h00, 32'he3a01a02,  8'h04, 2'd1};
        vec_a[2] = '{1'b0, 1'b1, 1'b1, 8'h04, 32'he3a02002,  8'h08, 2'd1};
        vec_a[3] = '{1'b0, 1'b1, 1'b1, 8'h08, 32'he5812000,  8'h0C, 2'd1};
        // ready low for 5 cycles: FIFO fills with 00/04, PC holds at 08
        vec_b[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 32'h0,         8'h00, 2'd1};
        vec_b[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 32'he3a01a02,  8'h04, 2'd1};
        vec_b[2] = '{1'b0, 1'b0, 1'b1, 8'h00, 32'he3a01a02,  8'h08, 2'd1};
        vec_b[3] = '{1'b0, 1'b0, 1'b1, 8'h00, 32'he3a01a02,  8'h08, 2'd1};
        vec_b[4] = '{1'b0, 1'b0, 1'b1, 8'h00, 32'he3a01a02,  8'h08, 2'd1};
        vec_b[5] = '{1'b0, 1'b1, 1'b1, 8'h04, 32'he3a02002,  8'h0C, 2'd1};
        vec_b[6] = '{1'b0, 1'b1, 1'b1, 8'h08, 32'he5812000,  8'h10, 2'd1};

        #2;
        reset_assert();
        reset_release();
        run_table("vecA", vec_a, 4);

        reset_assert();
        reset_release();
        run_table("vecB", vec_b, 7);

        // Redirect to 5A while full and popped: flush wins, two-cycle bubble
        reset_assert();
        reset_release();
        start = 1; tick(); start = 0;
        tick(); tick();
        chk("full.addr", {24'd0, imem_addr}, 32'h08);
        redirect_valid = 1; redirect_pc = 8'h5A; inst_ready = 1;
        tick();
        redirect_valid = 0;
        chk("redir5a.bubble", {31'd0, inst_valid}, 32'd0);
        chk("redir5a.addr", {24'd0, imem_addr}, 32'h58);
        tick();
        chk("redir5a.pc0", {24'd0, inst_pc}, 32'h58);
        chk("redir5a.d0", inst_data, 32'he5912000);
        tick();
        chk("redir5a.pc1", {24'd0, inst_pc}, 32'h5C);
        chk("redir5a.d1", inst_data, 32'he1e05002);

        // Redirect to FC: zero word passes through, PC wraps to 00
        redirect_valid = 1; redirect_pc = 8'hFC;
        tick();
        redirect_valid = 0;
        chk("redirfc.bubble", {31'd0, inst_valid}, 32'd0);
        tick();
        chk("redirfc.valid", {31'd0, inst_valid}, 32'd1);
        chk("redirfc.pc0", {24'd0, inst_pc}, 32'hFC);
        chk("redirfc.d0", inst_data, 32'h0);
        chk("redirfc.addr", {24'd0, imem_addr}, 32'h00);
        tick();
        chk("redirfc.pc1", {24'd0, inst_pc}, 32'h00);
        chk("redirfc.d1", inst_data, 32'he3a01a02);

        // Halt with 2 queued: drain, PC frozen; start+halt stays HALT
        reset_assert();
        reset_release();
        start = 1; tick(); start = 0;
        tick(); tick();
        halt = 1; inst_ready = 1;
        tick();
        chk("halt.state", {30'd0, state}, 32'd2);
        chk("halt.head", {24'd0, inst_pc}, 32'h04);
        tick();
        chk("halt.drained", {31'd0, inst_valid}, 32'd0);
        chk("halt.addr", {24'd0, imem_addr}, 32'h08);
        start = 1;
        tick();
        chk("halt.startwins", {30'd0, state}, 32'd2);
        halt = 0;
        tick();
        start = 0;
        chk("resume.state", {30'd0, state}, 32'd1);
        tick();
        chk("resume.pc", {24'd0, inst_pc}, 32'h08);
        chk("resume.data", inst_data, 32'he5812000);

        // Reset mid-RUN with FIFO non-empty, asserted between edges
        inst_ready = 0;
        tick();
        #2;
        reset_assert();
        reset_release();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            start          = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) == 0) halt = ~halt;
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = 8'($urandom);
            inst_ready     = ($urandom_range(0, 9) < 7);
            tick();
            if ($urandom_range(0, 499) == 0) begin
                #2;
                reset_assert();
                reset_release();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
